// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
//   pwm_mode_e : channel alignment mode (EDGE = sawtooth, CENTER = triangle)
//   NUM_CH_DEF / CNT_W_DEF : default channel count and counter width
//   ch_w()     : channel index width, never less than one bit
package pwm_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  function automatic int unsigned ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Configuration write bus for pwm_multi_channel.
//   cfg_valid  : write request (master)
//   cfg_ready  : write accepted when high together with cfg_valid (slave)
//   cfg_ch     : target channel
//   cfg_period : period (edge mode) or half-period (center mode) in clocks
//   cfg_duty   : high time in clocks
//   cfg_center : 0 = edge-aligned, 1 = center-aligned
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int unsigned CH_W  = ch_w(NUM_CH_DEF),
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_center;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_duty, cfg_center,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_duty, cfg_center,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel with double-buffered configuration.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   en_i, sync_i    : global run, counter restart
//   wr_i, wr_*_i    : shadow register load (period, duty, mode)
//   pend_o          : shadow holds a not-yet-applied configuration
//   active_o        : active period is non-zero
//   pwm_o, pe_o     : registered PWM output and period-end pulse
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic [CNT_W-1:0] wr_duty_i,
  input  pwm_mode_e        wr_mode_i,
  output logic             pend_o,
  output logic             active_o,
  output logic             pwm_o,
  output logic             pe_o
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    pwm_mode_e        mode;
  } cfg_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  cfg_t             act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;    // counter is live in the current cycle
  logic             down_q, down_d;  // center mode down phase
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d, pe_q, pe_d;
  logic             apply;

  always_comb begin
    // Shadow takes over at a period boundary, on restart, or whenever the channel is idle.
    apply  = pend_q && (sync_i || !en_i || !run_q || pe_q);
    act_d  = apply ? shd_q : act_q;
    shd_d  = shd_q;
    pend_d = pend_q && !apply;
    if (wr_i) begin
      shd_d  = '{period: wr_period_i, duty: wr_duty_i, mode: wr_mode_i};
      pend_d = 1'b1;
    end

    run_d  = en_i && (act_d.period != '0);
    cnt_d  = '0;
    down_d = 1'b0;
    // A fresh start or restart begins at zero; otherwise advance with the outgoing config,
    // which lands on zero/up exactly when a new config is applied at the period end.
    if (run_d && run_q && !sync_i) begin
      if (act_q.mode == EDGE) begin
        cnt_d = (cnt_q == act_q.period - CntOne) ? '0 : cnt_q + CntOne;
      end else if (!down_q) begin
        down_d = (cnt_q == act_q.period - CntOne);
        cnt_d  = down_d ? cnt_q : cnt_q + CntOne;
      end else begin
        down_d = (cnt_q != '0);
        cnt_d  = down_d ? cnt_q - CntOne : '0;
      end
    end

    pwm_d = run_d && (cnt_d < act_d.duty);
    pe_d  = run_d && ((act_d.mode == EDGE) ? (cnt_d == act_d.period - CntOne)
                                           : (down_d && (cnt_d == '0)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      down_q <= 1'b0;
      cnt_q  <= '0;
      pwm_q  <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      down_q <= down_d;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      pe_q   <= pe_d;
    end
  end

  assign pend_o   = pend_q;
  assign active_o = (act_q.period != '0);
  assign pwm_o    = pwm_q;
  assign pe_o     = pe_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: config decode, ready mux and busy reduction around
// NUM_CH pwm_channel instances.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : global run; low holds all channels idle
//   sync_in         : restart all channel counters
//   cfg             : configuration write bus (slave side)
//   pwm_out         : registered PWM outputs
//   period_end      : one-cycle pulse on the last cycle of each channel period
//   busy            : enable high and at least one channel has a non-zero period
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sync_in,
  pwm_multi_channel_if.slave  cfg,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic [NUM_CH-1:0]   period_end,
  output logic                busy
);

  localparam int unsigned NumSlots = 2 ** CH_W;

  logic [NUM_CH-1:0]   pend;
  logic [NUM_CH-1:0]   active;
  logic [NumSlots-1:0] pend_slot;
  logic                xfer;

  // Unpopulated channel indices read as never pending, so writes to them are
  // accepted and dropped.
  always_comb begin
    pend_slot              = '0;
    pend_slot[NUM_CH-1:0]  = pend;
  end

  assign cfg.cfg_ready = !pend_slot[cfg.cfg_ch];
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = enable && (|active);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (enable),
      .sync_i      (sync_in),
      .wr_i        (xfer && (cfg.cfg_ch == CH_W'(i))),
      .wr_period_i (cfg.cfg_period),
      .wr_duty_i   (cfg.cfg_duty),
      .wr_mode_i   (pwm_mode_e'(cfg.cfg_center)),
      .pend_o      (pend[i]),
      .active_o    (active[i]),
      .pwm_o       (pwm_out[i]),
      .pe_o        (period_end[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel. The reference model tracks each channel as
// a phase index within its period (length P or 2P) and derives the counter, output and
// period-end from that index.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int unsigned NUM_CH = 3;  // leaves channel index 3 unpopulated
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned VW     = 2 * NUM_CH + 2;

  logic              clk = 1'b0;
  logic              rst, enable, sync_in;
  logic [NUM_CH-1:0] pwm_out, period_end;
  logic              busy;

  pwm_multi_channel_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  pwm_multi_channel #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sync_in    (sync_in),
    .cfg        (cfg),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  bit m_run [NUM_CH];
  bit m_pend[NUM_CH];
  int m_k   [NUM_CH];
  int m_act_p[NUM_CH], m_act_d[NUM_CH];
  bit m_act_c[NUM_CH];
  int m_shd_p[NUM_CH], m_shd_d[NUM_CH];
  bit m_shd_c[NUM_CH];

  logic [VW-1:0] obs;
  assign obs = {pwm_out, period_end, busy, cfg.cfg_ready};

  function automatic int plen(int p, bit c);
    return c ? 2 * p : p;
  endfunction

  function automatic bit exp_ready();
    int c = int'(cfg.cfg_ch);
    if (c >= int'(NUM_CH)) return 1'b1;
    return !m_pend[c];
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NUM_CH-1:0] p, e;
    bit b;
    int l, v;
    p = '0;
    e = '0;
    b = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m_act_p[i] != 0) b = 1'b1;
      if (m_run[i]) begin
        l = plen(m_act_p[i], m_act_c[i]);
        v = (m_k[i] < m_act_p[i]) ? m_k[i] : l - 1 - m_k[i];
        p[i] = (v < m_act_d[i]);
        e[i] = (m_k[i] == l - 1);
      end
    end
    return {p, e, b && enable, exp_ready()};
  endfunction

  task automatic model_step();
    bit rdy, wr, at_end, apply, nrun;
    int lold;
    rdy = exp_ready();
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rst) begin
        m_run[i] = 0; m_pend[i] = 0; m_k[i] = 0;
        m_act_p[i] = 0; m_act_d[i] = 0; m_act_c[i] = 0;
        m_shd_p[i] = 0; m_shd_d[i] = 0; m_shd_c[i] = 0;
      end else begin
        wr     = cfg.cfg_valid && rdy && (int'(cfg.cfg_ch) == i);
        lold   = plen(m_act_p[i], m_act_c[i]);
        at_end = m_run[i] && (m_k[i] == lold - 1);
        apply  = m_pend[i] && (sync_in || !enable || !m_run[i] || at_end);
        if (apply) begin
          m_act_p[i] = m_shd_p[i]; m_act_d[i] = m_shd_d[i]; m_act_c[i] = m_shd_c[i];
          m_pend[i]  = 0;
        end
        if (wr) begin
          m_shd_p[i] = int'(cfg.cfg_period); m_shd_d[i] = int'(cfg.cfg_duty);
          m_shd_c[i] = cfg.cfg_center;       m_pend[i]  = 1;
        end
        nrun = enable && (m_act_p[i] != 0);
        if (!nrun || sync_in || !m_run[i]) m_k[i] = 0;
        else m_k[i] = (m_k[i] + 1) % lold;
        m_run[i] = nrun;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_cfg(input int ch, input int p, input int d, input bit c);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_ch     = CH_W'(ch);
    cfg.cfg_period = CNT_W'(p);
    cfg.cfg_duty   = CNT_W'(d);
    cfg.cfg_center = c;
  endtask

  // Waits (bounded) for the channel's shadow to be free, then performs one write.
  task automatic write_ready(input int ch, input int p, input int d, input bit c,
                             output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!m_pend[ch]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      set_cfg(ch, p, d, c);
      tick();
      cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    rst = 1'b1; enable = 1'b0; sync_in = 1'b0;
    cfg.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0);
    cfg.cfg_valid = 1'b0;
    tick();
    tick();
    want = {{NUM_CH{1'b0}}, {NUM_CH{1'b0}}, 1'b0, 1'b1};
    n_tests++;
    if (obs !== want) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs, want);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_edge();
    int n_hi = 0, n_pe = 0;
    set_cfg(0, 10, 3, 0);
    enable = 1'b1;
    tick();
    cfg.cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL edge cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
      if (i >= 10 && i < 30) begin
        n_hi += int'(pwm_out[0]);
        n_pe += int'(period_end[0]);
      end
    end
    n_tests++;
    if (n_hi != 6 || n_pe != 2) begin
      n_fail++; $display("FAIL edge_counts got hi=%0d pe=%0d want hi=6 pe=2", n_hi, n_pe);
    end
  endtask

  task automatic test_center();
    int n_hi = 0, n_pe = 0;
    set_cfg(1, 8, 2, 1);
    tick();
    cfg.cfg_valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL center cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
      if (i >= 8 && i < 40) begin
        n_hi += int'(pwm_out[1]);
        n_pe += int'(period_end[1]);
      end
    end
    n_tests++;
    if (n_hi != 8 || n_pe != 2) begin
      n_fail++; $display("FAIL center_counts got hi=%0d pe=%0d want hi=8 pe=2", n_hi, n_pe);
    end
  endtask

  task automatic test_shadow();
    int n_hi = 0;
    int t = 0;
    while (m_k[0] != 4 && t < 30) begin
      tick();
      t++;
    end
    n_tests++;
    if (m_k[0] != 4) begin
      n_fail++; $display("FAIL shadow_wait got timeout want counter 4");
    end
    set_cfg(0, 10, 7, 0);
    tick();
    n_tests++;
    if (cfg.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL shadow_ready got=%b want=0", cfg.cfg_ready);
    end
    set_cfg(0, 10, 5, 0);  // second write held until the shadow frees up
    for (int i = 0; i < 34; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL shadow cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
      if (i < 14) n_hi += int'(pwm_out[0]);
    end
    cfg.cfg_valid = 1'b0;
    n_tests++;
    if (n_hi != 7) begin
      n_fail++; $display("FAIL shadow_duty got hi=%0d want hi=7", n_hi);
    end
  endtask

  task automatic test_sync();
    bit ok0, ok1;
    int t = 0;
    write_ready(0, 10, 3, 0, ok0);
    write_ready(1, 10, 5, 0, ok1);
    n_tests++;
    if (!(ok0 && ok1)) begin
      n_fail++; $display("FAIL sync_write got timeout want write accepted");
    end
    for (int i = 0; i < 25; i++) tick();
    while (m_k[0] != 6 && t < 30) begin
      tick();
      t++;
    end
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    n_tests++;
    if (pwm_out[1:0] !== 2'b11 || period_end !== '0) begin
      n_fail++; $display("FAIL sync_restart got pwm=%b pe=%b want pwm=x11 pe=0",
                         pwm_out, period_end);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec() || period_end[0] !== period_end[1]) begin
        n_fail++; $display("FAIL sync cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    int bad;
    for (int s = 0; s < 2; s++) begin
      write_ready(0, 10, (s == 0) ? 0 : 12, 0, ok);
      bad = ok ? 0 : 1;
      for (int i = 0; i < 25; i++) begin
        tick();
        n_tests++;
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL extreme cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
        end
        if (i >= 12 && pwm_out[0] !== ((s == 0) ? 1'b0 : 1'b1)) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL extreme_level s=%0d got %0d bad cycles want 0", s, bad);
      end
    end
    write_ready(0, 0, 0, 0, ok);
    write_ready(1, 0, 0, 0, ok);
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL zero_period cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
    end
    n_tests++;
    if (busy !== 1'b0 || pwm_out !== '0 || period_end !== '0) begin
      n_fail++; $display("FAIL zero_idle got busy=%b pwm=%b pe=%b want 0 0 0",
                         busy, pwm_out, period_end);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    logic [VW-1:0] want;
    write_ready(0, 10, 3, 0, ok);
    while (!(m_run[0] && m_k[0] == 1) && t < 30) begin
      tick();
      t++;
    end
    n_tests++;
    if (pwm_out[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre got pwm0=%b want 1", pwm_out[0]);
    end
    rst = 1'b1;
    tick();
    want = {{NUM_CH{1'b0}}, {NUM_CH{1'b0}}, 1'b0, 1'b1};
    n_tests++;
    if (obs !== want) begin
      n_fail++; $display("FAIL rst_mid got=%h want=%h", obs, want);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs !== want) begin
      n_fail++; $display("FAIL rst_residual got=%h want=%h", obs, want);
    end
    cfg.cfg_ch = 2'd3;
    #1;
    n_tests++;
    if (cfg.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL bad_ch_ready got=%b want=1", cfg.cfg_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) enable = !enable;
      sync_in       = ($urandom_range(0, 29) == 0);
      cfg.cfg_valid = ($urandom_range(0, 9) < 4);
      cfg.cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg.cfg_period = CNT_W'($urandom_range(0, 12));
      cfg.cfg_duty   = CNT_W'($urandom_range(0, 14));
      cfg.cfg_center = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      end
    end
    rst = 1'b0; sync_in = 1'b0; cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_shadow();
    test_sync();
    test_extremes();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of period/duty/counter values.
REQ-003 SHALL have derived parameter CH_W = max(1, clog2(NUM_CH)), channel index width.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 enable  in  1  global run; low holds all channels idle.
REQ-008 sync_in  in  1  single-cycle restart of all channel counters.
REQ-009 cfg_valid  in  1  config write request.
REQ-010 cfg_ready  out  1  config write accepted when high with cfg_valid.
REQ-011 cfg_ch  in  CH_W  target channel.
REQ-012 cfg_period  in  CNT_W  period P in clocks (edge mode) or half-period (center mode).
REQ-013 cfg_duty  in  CNT_W  high time D in clocks per half/full period.
REQ-014 cfg_center  in  1  0 = edge-aligned, 1 = center-aligned.
REQ-015 pwm_out  out  NUM_CH  registered PWM outputs.
REQ-016 period_end  out  NUM_CH  one-cycle pulse on last cycle of each channel period.
REQ-017 busy  out  1  high when enable=1 and any channel has P != 0.

Function
REQ-018 Each channel SHALL hold active (P, D, mode) and shadow (P, D, mode, pending flag) registers.
REQ-019 Write handshake: transfer occurs on cycle with cfg_valid & cfg_ready; data loads shadow, sets pending.
REQ-020 cfg_ready SHALL be low only while pending is set for the channel addressed by cfg_ch.
REQ-021 Writes with cfg_ch >= NUM_CH SHALL be accepted (cfg_ready=1) and discarded.
REQ-022 Shadow SHALL copy to active on the cycle period_end pulses, or on the next cycle if channel idle; pending clears then.
REQ-023 Edge mode: counter 0,1,..,P-1, wraps to 0; pwm_out high when counter < D.
REQ-024 Center mode: counter up 0..P-1 then down P-1..0 (full cycle 2P clocks); pwm_out high when counter < D.
REQ-025 pwm_out and counter SHALL update on the same edge (zero added latency); first counter value 0 in first cycle after enable sampled high.
REQ-026 period_end SHALL pulse when counter = P-1 (edge) or counter = 0 in down phase (center).
REQ-027 D = 0: output constantly low; D >= P: output constantly high; period_end still pulses.
REQ-028 P = 0: channel idle, counter 0, output low, no period_end.
REQ-029 P = 1 edge mode: period_end high every cycle.
REQ-030 enable low: counters 0, direction up, pwm_out 0, period_end 0; pending shadows apply immediately.
REQ-031 sync_in high: all counters to 0, direction up, pending shadows applied that cycle; outputs recompare from counter 0; sync_in has priority over period wrap.
REQ-032 Write and period_end on same channel same cycle: old pending applies, new write loads shadow and stays pending.
REQ-033 Counter arithmetic SHALL be CNT_W-bit unsigned, no overflow since counter < P.

Reset
REQ-034 rst SHALL clear all counters, active and shadow registers, pending flags, direction to up.
REQ-035 After reset: pwm_out=0, period_end=0, busy=0, cfg_ready=1.
REQ-036 rst mid-period SHALL abort immediately; no residual pulse next cycle.

Structure
REQ-037 Package pwm_pkg SHALL hold mode enum (EDGE, CENTER), default NUM_CH/CNT_W constants, channel config struct.
REQ-038 Per-channel logic SHALL be sub-module pwm_channel, instantiated NUM_CH times via generate.
REQ-039 Top-level SHALL contain only config decode, cfg_ready mux and busy reduction.

Verification
REQ-040 Ch0 edge P=10 D=3, enable -> pwm_out[0] high 3 of every 10 clocks, period_end[0] every 10th clock.
REQ-041 Ch1 center P=8 D=2 -> 16-clock cycle, high 4 clocks centred on counter 0, period_end once per 16.
REQ-042 Ch0 running P=10 D=3, write D=7 at counter 4 -> current period keeps D=3, next period D=7; second write before apply sees cfg_ready=0.
REQ-043 D=0 -> pwm_out constant 0; D=12 with P=10 -> constant 1; P=0 -> output 0, busy=0 if only channel.
REQ-044 Two channels P=10, sync_in pulse at ch0 counter 6 -> both counters 0 next cycle, outputs phase-aligned.
REQ-045 rst asserted mid-high pulse -> pwm_out=0 and cfg_ready=1 next cycle, all config cleared.
